// File: rtl/l2l_bram_tx.sv
// Inter-layer BRAM write transmitter: staging FIFO feeding the next layer's input-BRAM write port.
// Build option: define L2L_TX_RELU_EN to clamp negative lanes to zero at the output register.
module l2l_bram_tx #(
    parameter int M           = 16,
    parameter int DW          = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int FRAME_WORDS = 676,
    parameter int FIFO_DEPTH  = 4,
    parameter int FINAL_PHASE = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [M*DW-1:0]       in_data,
    output logic                  in_ready,
    input  logic                  dn_hold,
    output logic                  ld_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [M*DW-1:0]       data_out,
    output logic [2:0]            u_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic [1:0]            dbg_state
);
    localparam int W  = M * DW;
    localparam int CW = ADDR_WIDTH + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FW    = CW'(FRAME_WORDS);
    localparam logic [PW:0]   DEPTH = (PW + 1)'(FIFO_DEPTH);
    localparam logic [2:0]    PHASE = 3'(FINAL_PHASE);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    // Handshake: a word moves when in_valid && in_ready at a rising edge; upstream holds it otherwise.
    state_t            state_q, state_d;
    logic [CW-1:0]     acc_cnt_q, acc_cnt_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [W-1:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q;
    logic              ld_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [W-1:0]      data_q;
    logic              push, pop, fifo_full, fifo_empty, active;

    function automatic logic [W-1:0] out_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = w;
`ifdef L2L_TX_RELU_EN
        for (int l = 0; l < M; l++) begin
            if (w[l*DW + DW - 1]) r[l*DW +: DW] = '0;
        end
`endif
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        fifo_full  = (count_q == DEPTH);
        fifo_empty = (count_q == '0);
        active     = (state_q == S_STREAM) || (state_q == S_DRAIN);
        in_ready   = (state_q == S_STREAM) && !fifo_full && (acc_cnt_q < FW);
        push       = in_valid && in_ready;
        pop        = active && !fifo_empty && !dn_hold && (wr_cnt_q < FW);
        if (push) acc_cnt_d = acc_cnt_q + CW'(1);
        if (pop)  wr_cnt_d  = wr_cnt_q + CW'(1);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_STREAM;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                end
            end
            S_STREAM: if (acc_cnt_q == FW) state_d = S_DRAIN;
            S_DRAIN:  if (wr_cnt_q == FW)  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ld_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + (PW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PW + 1)'(1);
            ld_q <= pop;
            // Address and data hold their last value between writes.
            if (pop) begin
                addr_q <= wr_cnt_q[ADDR_WIDTH-1:0];
                data_q <= out_word(mem_q[rd_ptr_q]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign ld_out     = ld_q;
    assign addr_out   = addr_q;
    assign data_out   = data_q;
    assign u_out      = (state_q == S_IDLE) ? 3'd0 : PHASE;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_l2l_bram_tx.sv
// Bench for l2l_bram_tx: a 676-word and a 1024-word instance share one stimulus path chosen by sel;
// a monitor compares every write against an expected queue built from the accepted words.
`timescale 1ns/1ps
module tb_l2l_bram_tx;
    localparam int M = 16, DW = 16, AW = 10, W = M * DW;
    localparam int FW_A = 676, FW_B = 1024, DEPTH = 4;
    localparam logic [2:0] PHASE = 3'd5;
`ifdef L2L_TX_RELU_EN
    localparam logic [DW-1:0] NEG_LANE_EXP = 16'h0000;
`else
    localparam logic [DW-1:0] NEG_LANE_EXP = 16'hFFF0;
`endif

    logic clk = 1'b0;
    logic rst, start, in_valid, dn_hold, sel;
    logic [W-1:0] in_data;

    logic rdy_a, ld_a, busy_a, fd_a, rdy_b, ld_b, busy_b, fd_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [W-1:0] data_a, data_b;
    logic [2:0] u_a, u_b;
    logic [1:0] dbg_a, dbg_b;

    logic m_ready, m_ld, m_busy, m_fd;
    logic [AW-1:0] m_addr;
    logic [W-1:0] m_data;
    logic [2:0] m_u;

    int tests_run = 0, tests_failed = 0;
    int done_cnt = 0, ld_total = 0, wr_idx = 0, next_idx = 0;
    logic [AW-1:0] last_addr;
    logic [W-1:0] first_data, cur_word;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    l2l_bram_tx #(.M(M), .DW(DW), .ADDR_WIDTH(AW), .FRAME_WORDS(FW_A), .FIFO_DEPTH(DEPTH), .FINAL_PHASE(5)) dut_a (
        .clk(clk), .rst(rst), .start(start && !sel), .in_valid(in_valid && !sel), .in_data(in_data),
        .in_ready(rdy_a), .dn_hold(dn_hold), .ld_out(ld_a), .addr_out(addr_a), .data_out(data_a),
        .u_out(u_a), .busy(busy_a), .frame_done(fd_a), .dbg_state(dbg_a));

    l2l_bram_tx #(.M(M), .DW(DW), .ADDR_WIDTH(AW), .FRAME_WORDS(FW_B), .FIFO_DEPTH(DEPTH), .FINAL_PHASE(5)) dut_b (
        .clk(clk), .rst(rst), .start(start && sel), .in_valid(in_valid && sel), .in_data(in_data),
        .in_ready(rdy_b), .dn_hold(dn_hold), .ld_out(ld_b), .addr_out(addr_b), .data_out(data_b),
        .u_out(u_b), .busy(busy_b), .frame_done(fd_b), .dbg_state(dbg_b));

    assign m_ready = sel ? rdy_b  : rdy_a;
    assign m_ld    = sel ? ld_b   : ld_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_fd    = sel ? fd_b   : fd_a;
    assign m_addr  = sel ? addr_b : addr_a;
    assign m_data  = sel ? data_b : data_a;
    assign m_u     = sel ? u_b    : u_a;

    function automatic logic [W-1:0] mk_word(input int idx);
        logic [W-1:0] w;
        for (int l = 0; l < M; l++) w[l*DW +: DW] = DW'($urandom);
        w[DW-1:0] = DW'(idx);
        return w;
    endfunction

    // Reference: a lane is a signed DW-bit number; negative lanes read back as zero when clamping.
    function automatic logic [W-1:0] relu_ref(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = w;
`ifdef L2L_TX_RELU_EN
        for (int l = 0; l < M; l++) begin
            if ($signed(w[l*DW +: DW]) < 0) r[l*DW +: DW] = '0;
        end
`endif
        return r;
    endfunction

    task automatic monitor();
        bit prev_last, prev_fd;
        logic [W-1:0] exp;
        int fw;
        prev_last = 0;
        prev_fd = 0;
        forever begin
            @(negedge clk);
            fw = sel ? FW_B : FW_A;
            if (m_ld === 1'b1) begin
                ld_total++;
                if (wr_idx == 0) first_data = m_data;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_write addr=%0d (no word pending)", m_addr);
                end else begin
                    exp = exp_q.pop_front();
                    if (m_data !== exp) begin
                        tests_failed++;
                        $display("FAIL write_data idx=%0d got=%h exp=%h", wr_idx, m_data, exp);
                    end
                end
                tests_run++;
                if (m_addr !== AW'(wr_idx)) begin
                    tests_failed++;
                    $display("FAIL write_addr got=%0d exp=%0d", m_addr, wr_idx);
                end
                tests_run++;
                if (m_u !== PHASE) begin
                    tests_failed++;
                    $display("FAIL u_during_write got=%0d exp=%0d", m_u, PHASE);
                end
                last_addr = m_addr;
                wr_idx++;
            end
            if (m_fd === 1'b1) begin
                done_cnt++;
                tests_run++;
                if (!prev_last || exp_q.size() != 0) begin
                    tests_failed++;
                    $display("FAIL frame_done_timing prev_last=%0d pending=%0d exp prev_last=1 pending=0",
                             prev_last, exp_q.size());
                end
            end else if (prev_last) begin
                tests_run++;
                tests_failed++;
                $display("FAIL frame_done_missing got=0 exp=1");
            end
            if (prev_fd) begin
                tests_run++;
                if (m_u !== 3'd0 || m_busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL after_done u=%0d busy=%0d exp u=0 busy=0", m_u, m_busy);
                end
            end
            prev_last = (m_ld === 1'b1) && (wr_idx == fw);
            prev_fd = (m_fd === 1'b1);
            if (m_busy !== 1'b1) wr_idx = 0;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drive(input int n, input int max_cyc, input bit hold_rand, output int acc, output int cyc);
        acc = 0;
        cyc = 0;
        @(posedge clk); #1;
        while (acc < n && cyc < max_cyc) begin
            if (hold_rand) dn_hold = ($urandom_range(0, 3) == 0);
            in_valid = 1'b1;
            in_data = cur_word;
            @(negedge clk);
            if (m_ready === 1'b1) begin
                exp_q.push_back(relu_ref(cur_word));
                acc++;
                next_idx++;
                cur_word = mk_word(next_idx);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (hold_rand) dn_hold = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit hold_rand);
        int c, d0;
        c = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && c < bound) begin
            if (hold_rand) dn_hold = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            c++;
        end
        dn_hold = 1'b0;
        tests_run++;
        if (done_cnt == d0) begin
            tests_failed++;
            $display("FAIL frame_done_timeout waited=%0d cycles exp a pulse", c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; dn_hold = 1'b0; sel = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({rdy_a, ld_a, busy_a, fd_a, u_a} !== 7'b0 || addr_a !== '0 || data_a !== '0) begin
            tests_failed++;
            $display("FAIL reset_a rdy=%0d ld=%0d busy=%0d fd=%0d u=%0d addr=%0d data=%h exp all 0",
                     rdy_a, ld_a, busy_a, fd_a, u_a, addr_a, data_a);
        end
        tests_run++;
        if ({rdy_b, ld_b, busy_b, fd_b, u_b} !== 7'b0 || addr_b !== '0 || data_b !== '0) begin
            tests_failed++;
            $display("FAIL reset_b rdy=%0d ld=%0d busy=%0d fd=%0d u=%0d addr=%0d exp all 0",
                     rdy_b, ld_b, busy_b, fd_b, u_b, addr_b);
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset busy_a=%0d busy_b=%0d exp 0", busy_a, busy_b);
        end
    endtask

    task automatic test_back_to_back();
        int acc, cyc, d0, l0;
        sel = 1'b0;
        d0 = done_cnt;
        l0 = ld_total;
        pulse_start();
        in_valid = 1'b1;
        in_data = cur_word;
        @(negedge clk);
        tests_run++;
        if (m_busy !== 1'b1 || m_u !== PHASE || m_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_response busy=%0d u=%0d ready=%0d exp 1/5/1", m_busy, m_u, m_ready);
        end
        if (m_ready === 1'b1) begin
            exp_q.push_back(relu_ref(cur_word));
            next_idx++;
            cur_word = mk_word(next_idx);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (m_ld !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early ld=%0d exp 0 one edge after accept", m_ld);
        end
        @(negedge clk);
        tests_run++;
        if (m_ld !== 1'b1 || m_addr !== '0) begin
            tests_failed++;
            $display("FAIL latency_two ld=%0d addr=%0d exp ld=1 addr=0", m_ld, m_addr);
        end
        drive(FW_A - 1, 3000, 1'b0, acc, cyc);
        tests_run++;
        if (acc != FW_A - 1 || cyc != FW_A - 1) begin
            tests_failed++;
            $display("FAIL throughput accepted=%0d cycles=%0d exp %0d/%0d", acc, cyc, FW_A - 1, FW_A - 1);
        end
        in_valid = 1'b1;
        in_data = cur_word;
        @(negedge clk);
        tests_run++;
        if (m_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_after_frame got=%0d exp 0", m_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        wait_done(3000, 1'b0);
        tests_run++;
        if (done_cnt != d0 + 1 || ld_total - l0 != FW_A) begin
            tests_failed++;
            $display("FAIL b2b_counts frames=%0d writes=%0d exp 1/%0d", done_cnt - d0, ld_total - l0, FW_A);
        end
    endtask

    task automatic test_hold();
        int acc, cyc, d0, l0, l1;
        sel = 1'b0;
        d0 = done_cnt;
        l0 = ld_total;
        pulse_start();
        drive(200, 2000, 1'b0, acc, cyc);
        repeat (4) @(posedge clk);
        #1 dn_hold = 1'b1;
        l1 = ld_total;
        drive(100, 10, 1'b0, acc, cyc);
        tests_run++;
        if (acc != DEPTH) begin
            tests_failed++;
            $display("FAIL hold_accepts got=%0d exp=%0d", acc, DEPTH);
        end
        @(negedge clk);
        tests_run++;
        if (m_ready !== 1'b0 || ld_total != l1) begin
            tests_failed++;
            $display("FAIL hold_stall ready=%0d writes=%0d exp 0/0", m_ready, ld_total - l1);
        end
        dn_hold = 1'b0;
        drive(FW_A - 200 - DEPTH, 5000, 1'b1, acc, cyc);
        wait_done(5000, 1'b1);
        tests_run++;
        if (done_cnt != d0 + 1 || ld_total - l0 != FW_A) begin
            tests_failed++;
            $display("FAIL hold_counts frames=%0d writes=%0d exp 1/%0d", done_cnt - d0, ld_total - l0, FW_A);
        end
    endtask

    task automatic test_ignored();
        int acc, cyc, d0, l0, bad;
        sel = 1'b0;
        d0 = done_cnt;
        l0 = ld_total;
        bad = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = cur_word;
        repeat (20) begin
            @(negedge clk);
            if (m_ready !== 1'b0 || m_busy !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (bad != 0 || ld_total != l0) begin
            tests_failed++;
            $display("FAIL idle_in_valid bad_cycles=%0d writes=%0d exp 0/0", bad, ld_total - l0);
        end
        pulse_start();
        drive(100, 1000, 1'b0, acc, cyc);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        drive(FW_A - 100, 5000, 1'b1, acc, cyc);
        wait_done(5000, 1'b1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_busy !== 1'b0 || m_ld !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0 || done_cnt != d0 + 1 || ld_total - l0 != FW_A) begin
            tests_failed++;
            $display("FAIL start_ignored bad=%0d frames=%0d writes=%0d exp 0/1/%0d",
                     bad, done_cnt - d0, ld_total - l0, FW_A);
        end
    endtask

    task automatic test_reset_mid();
        int acc, cyc, d0, l0;
        sel = 1'b0;
        d0 = done_cnt;
        pulse_start();
        drive(300, 3000, 1'b1, acc, cyc);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if ({m_ready, m_ld, m_busy, m_fd, m_u} !== 7'b0 || m_addr !== '0 || m_data !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs rdy=%0d ld=%0d busy=%0d fd=%0d u=%0d addr=%0d exp all 0",
                     m_ready, m_ld, m_busy, m_fd, m_u, m_addr);
        end
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++;
        if (done_cnt != d0) begin
            tests_failed++;
            $display("FAIL mid_reset_done frames=%0d exp 0", done_cnt - d0);
        end
        l0 = ld_total;
        pulse_start();
        drive(FW_A, 5000, 1'b1, acc, cyc);
        wait_done(5000, 1'b1);
        tests_run++;
        if (done_cnt != d0 + 1 || ld_total - l0 != FW_A) begin
            tests_failed++;
            $display("FAIL restart_counts frames=%0d writes=%0d exp 1/%0d", done_cnt - d0, ld_total - l0, FW_A);
        end
    endtask

    task automatic test_big_frame();
        int acc, cyc, d0, l0, l1, bad;
        sel = 1'b1;
        d0 = done_cnt;
        l0 = ld_total;
        pulse_start();
        drive(FW_B - 1, 8000, 1'b1, acc, cyc);
        repeat (6) @(posedge clk);
        #1 dn_hold = 1'b1;
        drive(1, 10, 1'b0, acc, cyc);
        tests_run++;
        if (acc != 1) begin
            tests_failed++;
            $display("FAIL big_last_accept got=%0d exp 1", acc);
        end
        l1 = ld_total;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_ld !== 1'b0 || m_fd !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0 || ld_total != l1 || done_cnt != d0) begin
            tests_failed++;
            $display("FAIL big_hold bad=%0d writes=%0d frames=%0d exp 0/0/0", bad, ld_total - l1, done_cnt - d0);
        end
        dn_hold = 1'b0;
        wait_done(100, 1'b0);
        tests_run++;
        if (last_addr !== AW'(FW_B - 1) || done_cnt != d0 + 1 || ld_total - l0 != FW_B) begin
            tests_failed++;
            $display("FAIL big_final last_addr=%0d frames=%0d writes=%0d exp %0d/1/%0d",
                     last_addr, done_cnt - d0, ld_total - l0, FW_B - 1, FW_B);
        end
        sel = 1'b0;
    endtask

    task automatic test_relu();
        int acc, cyc, d0;
        sel = 1'b0;
        d0 = done_cnt;
        cur_word = {M{16'hFFF0}};
        pulse_start();
        drive(1, 100, 1'b0, acc, cyc);
        drive(FW_A - 1, 5000, 1'b1, acc, cyc);
        wait_done(5000, 1'b1);
        tests_run++;
        if (first_data !== {M{NEG_LANE_EXP}}) begin
            tests_failed++;
            $display("FAIL relu_lane got=%h exp=%h", first_data[DW-1:0], NEG_LANE_EXP);
        end
        tests_run++;
        if (done_cnt != d0 + 1) begin
            tests_failed++;
            $display("FAIL relu_frame frames=%0d exp 1", done_cnt - d0);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; dn_hold = 1'b0; sel = 1'b0; in_data = '0;
        cur_word = mk_word(0);
        fork
            monitor();
        join_none
        test_reset();
        test_back_to_back();
        test_hold();
        test_ignored();
        test_reset_mid();
        test_big_frame();
        test_relu();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
